sync_fifo_ram: RTL and testbench

- Parametrised single-clock FIFO built on an inferred simple dual-port RAM. It is the next-generation buffer for the logic-analysis capture path.
- Adds occupancy tracking, full/empty and programmable almost-full/almost-empty flags, overflow/underflow detection, and a selectable standard or first-word-fall-through (FWFT) read mode.
- Sits between the sample/trigger logic (writer) and the readout/UART side (reader), both in the same clock domain.

---
 rtl/sync_fifo_ram_pkg.sv | 7 +
 rtl/sync_fifo_ram_sdpram_core.sv | 35 +++
 rtl/sync_fifo_ram.sv | 106 ++++++++++
 tb/tb_sync_fifo_ram.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_ram_pkg.sv
// Shared definitions for the capture-path FIFO.
// FIFO_MODE_STD  : standard read, data one clock after ren.
// FIFO_MODE_FWFT : first-word-fall-through, head word presented on dout.
package sync_fifo_ram_pkg;
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;
endpackage

// File: rtl/sync_fifo_ram_sdpram_core.sv
// Single-clock simple dual-port RAM with registered, enabled read port.
// A read and write to the same address in one cycle returns the old word.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset (clears only the read register)
//   we    - write enable, waddr/wdata - write address and data
//   re    - read enable, raddr - read address
//   rdata - registered read data, held while re is low
module sdpram_core #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Array kept in its own block without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO on an inferred simple dual-port RAM, with occupancy,
// full/empty, almost-full/almost-empty, overflow/underflow, and a
// standard or first-word-fall-through read mode.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   din, wen            - write data and request (accepted when !full)
//   ren                 - read request (standard) / pop (FWFT)
//   dout, dout_vld      - read data and its valid flag
//   full, empty         - occupancy flags
//   almost_full/empty   - threshold flags from count
//   count               - words accepted and not yet popped
//   overflow/underflow  - one-cycle pulses for rejected write/read
module sync_fifo_ram
  import sync_fifo_ram_pkg::*;
#(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 64,
  parameter int FWFT          = FIFO_MODE_STD,
  parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wen,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_vld,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                MEM_DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  localparam bit                  IS_FWFT = (FWFT == FIFO_MODE_FWFT);

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  wr_ok, rd_ok, prefetch, ram_re;

  assign wr_ok = wen && !full;
  assign rd_ok = ren && !empty;

  // In FWFT the head word sits in the RAM output register, so the RAM
  // itself holds count minus the head. Same-edge writes are not counted,
  // which keeps the prefetch address away from the write address.
  always_comb begin
    ram_cnt  = count - {{ADDR_WIDTH{1'b0}}, dout_vld};
    prefetch = (!dout_vld || rd_ok) && (ram_cnt != '0);
    ram_re   = IS_FWFT ? prefetch : rd_ok;
  end

  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign empty        = IS_FWFT ? !dout_vld : (count == '0);

  sdpram_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wptr),
    .wdata (din),
    .re    (ram_re),
    .raddr (rptr),
    .rdata (dout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      dout_vld  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wen && full;
      underflow <= ren && empty;
      if (wr_ok)  wptr <= wptr + 1'b1;
      if (ram_re) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (IS_FWFT) begin
        if (prefetch)   dout_vld <= 1'b1;
        else if (rd_ok) dout_vld <= 1'b0;
      end else begin
        dout_vld <= rd_ok;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_ram.sv
module tb_sync_fifo_ram;
  localparam int AW = 3;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] s_din = '0, f_din = '0;
  logic          s_wen = 1'b0, s_ren = 1'b0, f_wen = 1'b0, f_ren = 1'b0;
  logic [DW-1:0] s_dout, f_dout;
  logic          s_vld, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic          f_vld, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [AW:0]   s_count, f_count;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] exp_w;

  always #5 clk = ~clk;

  sync_fifo_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0),
                  .AFULL_THRESH(6), .AEMPTY_THRESH(1)) u_std (
    .clk(clk), .rst(rst), .din(s_din), .wen(s_wen), .ren(s_ren),
    .dout(s_dout), .dout_vld(s_vld), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf));

  sync_fifo_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1),
                  .AFULL_THRESH(6), .AEMPTY_THRESH(1)) u_fwft (
    .clk(clk), .rst(rst), .din(f_din), .wen(f_wen), .ren(f_ren),
    .dout(f_dout), .dout_vld(f_vld), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf));

  // Advance one rising edge; outputs are sampled and inputs driven 1 time
  // unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_wen = 1'b1; f_wen = 1'b1; s_din = 16'hFFFF; f_din = 16'hFFFF;
    tick();
    rst = 1'b0; s_wen = 1'b0; f_wen = 1'b0;
    checks++; if (s_count !== 4'd0) begin errors++; $display("FAIL reset_std_count got %0d exp 0", s_count); end
    checks++; if ({s_empty, s_ae, s_full, s_af, s_vld, s_ovf, s_unf} !== 7'b1100000) begin errors++; $display("FAIL reset_std_flags got %b exp 1100000", {s_empty, s_ae, s_full, s_af, s_vld, s_ovf, s_unf}); end
    checks++; if (s_dout !== 16'h0000) begin errors++; $display("FAIL reset_std_dout got %h exp 0000", s_dout); end
    checks++; if (f_count !== 4'd0) begin errors++; $display("FAIL reset_fwft_count got %0d exp 0", f_count); end
    checks++; if ({f_empty, f_ae, f_full, f_af, f_vld, f_ovf, f_unf} !== 7'b1100000) begin errors++; $display("FAIL reset_fwft_flags got %b exp 1100000", {f_empty, f_ae, f_full, f_af, f_vld, f_ovf, f_unf}); end
    checks++; if (f_dout !== 16'h0000) begin errors++; $display("FAIL reset_fwft_dout got %h exp 0000", f_dout); end
  endtask

  task automatic test_std_fill_drain();
    sb_q.delete();
    for (int i = 1; i <= 8; i++) begin
      s_wen = 1'b1; s_din = 16'(i);
      tick();
      sb_q.push_back(16'(i));
      checks++; if (s_count !== 4'(i)) begin errors++; $display("FAIL fill_count got %0d exp %0d", s_count, i); end
      checks++; if ({s_full, s_af, s_ae, s_empty} !== {(i == 8), (i >= 6), (i <= 1), 1'b0}) begin errors++; $display("FAIL fill_flags i=%0d got %b exp %b", i, {s_full, s_af, s_ae, s_empty}, {(i == 8), (i >= 6), (i <= 1), 1'b0}); end
    end
    s_din = 16'hDEAD;
    tick();
    s_wen = 1'b0;
    checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL overflow_pulse got %b exp 1", s_ovf); end
    checks++; if (s_count !== 4'd8) begin errors++; $display("FAIL overflow_count got %0d exp 8", s_count); end
    tick();
    checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL overflow_clear got %b exp 0", s_ovf); end
    s_ren = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_w = sb_q.pop_front();
      checks++; if (s_vld !== 1'b1) begin errors++; $display("FAIL drain_vld i=%0d got %b exp 1", i, s_vld); end
      checks++; if (s_dout !== exp_w) begin errors++; $display("FAIL drain_data i=%0d got %h exp %h", i, s_dout, exp_w); end
    end
    s_ren = 1'b0;
    checks++; if ({s_empty, s_count} !== {1'b1, 4'd0}) begin errors++; $display("FAIL drain_empty got %b/%0d exp 1/0", s_empty, s_count); end
    tick();
    checks++; if ({s_vld, s_dout} !== {1'b0, 16'h0008}) begin errors++; $display("FAIL drain_hold got %b/%h exp 0/0008", s_vld, s_dout); end
  endtask

  task automatic test_std_underflow();
    s_ren = 1'b1;
    tick();
    s_ren = 1'b0;
    checks++; if (s_unf !== 1'b1) begin errors++; $display("FAIL underflow_pulse got %b exp 1", s_unf); end
    checks++; if ({s_vld, s_dout} !== {1'b0, 16'h0008}) begin errors++; $display("FAIL underflow_dout got %b/%h exp 0/0008", s_vld, s_dout); end
    tick();
    checks++; if (s_unf !== 1'b0) begin errors++; $display("FAIL underflow_clear got %b exp 0", s_unf); end
  endtask

  task automatic test_fwft_timing();
    f_wen = 1'b1; f_din = 16'h00AA;
    tick();
    f_wen = 1'b0;
    checks++; if ({f_count, f_vld, f_empty} !== {4'd1, 1'b0, 1'b1}) begin errors++; $display("FAIL fwft_edgeN got %0d/%b/%b exp 1/0/1", f_count, f_vld, f_empty); end
    tick();
    checks++; if ({f_vld, f_empty, f_dout} !== {1'b1, 1'b0, 16'h00AA}) begin errors++; $display("FAIL fwft_edgeN1 got %b/%b/%h exp 1/0/00aa", f_vld, f_empty, f_dout); end
    f_ren = 1'b1;
    tick();
    f_ren = 1'b0;
    checks++; if ({f_vld, f_count, f_empty} !== {1'b0, 4'd0, 1'b1}) begin errors++; $display("FAIL fwft_pop got %b/%0d/%b exp 0/0/1", f_vld, f_count, f_empty); end
  endtask

  task automatic test_fwft_stream();
    int budget;
    sb_q.delete();
    f_wen = 1'b1; f_ren = 1'b1;
    for (int c = 0; c < 20; c++) begin
      f_din = 16'h0100 + 16'(c);
      // A pop happens at this edge iff the head is valid now; its word must
      // be the oldest one still in the scoreboard.
      if (f_vld) begin
        exp_w = sb_q.pop_front();
        checks++; if (f_dout !== exp_w) begin errors++; $display("FAIL stream_data c=%0d got %h exp %h", c, f_dout, exp_w); end
      end
      tick();
      sb_q.push_back(16'h0100 + 16'(c));
      if (c >= 1) begin
        checks++; if ({f_vld, f_count} !== {1'b1, 4'd2}) begin errors++; $display("FAIL stream_steady c=%0d got %b/%0d exp 1/2", c, f_vld, f_count); end
      end
    end
    f_wen = 1'b0;
    budget = 10;
    while (f_vld && budget > 0) begin
      exp_w = sb_q.pop_front();
      checks++; if (f_dout !== exp_w) begin errors++; $display("FAIL stream_tail got %h exp %h", f_dout, exp_w); end
      tick();
      budget--;
    end
    f_ren = 1'b0;
    checks++; if (budget == 0) begin errors++; $display("FAIL stream_drain_timeout got vld=%b exp 0", f_vld); end
    checks++; if ({f_count, 32'(sb_q.size())} !== {4'd0, 32'd0}) begin errors++; $display("FAIL stream_end got count=%0d left=%0d exp 0/0", f_count, sb_q.size()); end
  endtask

  task automatic test_full_simul();
    sb_q.delete();
    for (int i = 1; i <= 8; i++) begin
      s_wen = 1'b1; s_din = 16'h0100 + 16'(i);
      tick();
      sb_q.push_back(16'h0100 + 16'(i));
    end
    checks++; if (s_full !== 1'b1) begin errors++; $display("FAIL simul_prefull got %b exp 1", s_full); end
    s_wen = 1'b1; s_ren = 1'b1; s_din = 16'hBEEF;
    tick();
    s_wen = 1'b0;
    exp_w = sb_q.pop_front();
    checks++; if ({s_ovf, s_count} !== {1'b1, 4'd7}) begin errors++; $display("FAIL simul_full got %b/%0d exp 1/7", s_ovf, s_count); end
    checks++; if ({s_vld, s_dout} !== {1'b1, exp_w}) begin errors++; $display("FAIL simul_read got %b/%h exp 1/%h", s_vld, s_dout, exp_w); end
    for (int i = 0; i < 7; i++) begin
      tick();
      exp_w = sb_q.pop_front();
      checks++; if ({s_vld, s_dout} !== {1'b1, exp_w}) begin errors++; $display("FAIL simul_drain i=%0d got %b/%h exp 1/%h", i, s_vld, s_dout, exp_w); end
    end
    s_ren = 1'b0;
    checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL simul_empty got %b exp 1", s_empty); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) begin
      s_wen = 1'b1; s_din = 16'h0500 + 16'(i);
      tick();
    end
    rst = 1'b1; s_din = 16'h5555;
    tick();
    rst = 1'b0; s_wen = 1'b0;
    checks++; if ({s_count, s_empty, s_vld, s_dout} !== {4'd0, 1'b1, 1'b0, 16'h0000}) begin errors++; $display("FAIL midrst got %0d/%b/%b/%h exp 0/1/0/0000", s_count, s_empty, s_vld, s_dout); end
    s_wen = 1'b1; s_din = 16'h1234;
    tick();
    s_wen = 1'b0; s_ren = 1'b1;
    tick();
    s_ren = 1'b0;
    checks++; if ({s_vld, s_dout} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL midrst_first got %b/%h exp 1/1234", s_vld, s_dout); end
    checks++; if ({s_count, s_empty} !== {4'd0, 1'b1}) begin errors++; $display("FAIL midrst_after got %0d/%b exp 0/1", s_count, s_empty); end
  endtask

  initial begin
    tick();
    test_reset();
    test_std_fill_drain();
    test_std_underflow();
    test_fwft_timing();
    test_fwft_stream();
    test_full_simul();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
